fetch_queue: RTL and testbench

//  Instruction fetch queue between the instruction memory/PC stage and decode.
//  - Captures each {pc, instr} pair that fetch produces.
//  - Buffers up to DEPTH entries so fetch can run ahead when decode stalls.
//  - Presents entries in order to decode through a valid/ready handshake.
//  - flush_i (branch/jump redirect) discards every buffered entry.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fq_ptr.sv | 39 +++
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
//   XLEN_DEF   : default pc/instruction width
//   NOP_INSTR  : instruction shown on d_instr_o when the head is not valid
//   fq_entry_t : one queue slot, {pc, instr}
package fetch_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Wrapping pointer register used for the read and write sides of fetch_queue.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset, pointer -> 0
//   clr_i  : synchronous clear (flush), pointer -> 0
//   inc_i  : advance by one; wraps naturally from 2**W-1 to 0
//   ptr_o  : current pointer value
module fq_ptr #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch stage and decode.
// Buffers up to DEPTH {pc, instr} pairs in FIFO order; flush_i drops all of them.
// Optional build macro: FETCH_QUEUE_BYPASS_EN -- when the queue is empty, an
// incoming fetch is presented to decode in the same cycle.
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   flush_i    : synchronous flush (redirect), discards every entry
//   f_valid_i  : fetch presents {f_pc_i, f_instr_i}
//   f_pc_i     : pc of fetched instruction
//   f_instr_i  : fetched instruction word
//   f_ready_o  : queue can accept a push this cycle (never depends on d_ready_i)
//   d_valid_o  : head entry valid toward decode
//   d_pc_o     : head pc (0 when not valid)
//   d_instr_o  : head instruction (NOP_INSTR when not valid)
//   d_ready_i  : decode consumes the head this cycle
//   count_o    : number of stored entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             f_valid_i,
  input  logic [XLEN-1:0]  f_pc_i,
  input  logic [XLEN-1:0]  f_instr_i,
  output logic             f_ready_o,
  output logic             d_valid_o,
  output logic [XLEN-1:0]  d_pc_o,
  output logic [XLEN-1:0]  d_instr_o,
  input  logic             d_ready_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fq_entry_t        mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic      full;
  logic      empty;
  logic      push;
  logic      push_store;
  logic      pop_store;
  logic      bypass;
  logic      bypass_take;
  fq_entry_t entry_in;
  fq_entry_t head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign entry_in.pc    = f_pc_i;
  assign entry_in.instr = f_instr_i;

  assign f_ready_o = ~full & ~rst_i;
  assign push      = f_valid_i & f_ready_o & ~flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: hand the fetch straight to decode. rst_i gate keeps d_valid_o
  // low while reset is held even if fetch is still driving valid.
  assign bypass = empty & f_valid_i & ~flush_i & ~rst_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry that decode takes immediately never touches storage.
  assign bypass_take = bypass & d_ready_i;
  assign push_store  = push & ~bypass_take;
  // Only stored entries are popped; a bypass hand-off is not a pop.
  assign pop_store   = ~empty & ~flush_i & d_ready_i;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push_store) - CNT_W'(pop_store);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset; slot validity is tracked entirely by count_q.
  always_ff @(posedge clk_i) begin
    if (push_store) begin
      mem_q[wr_ptr] <= entry_in;
    end
  end

  fq_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (push_store),
    .ptr_o (wr_ptr)
  );

  fq_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (pop_store),
    .ptr_o (rd_ptr)
  );

  assign head      = bypass ? entry_in : mem_q[rd_ptr];
  assign d_valid_o = (~empty & ~flush_i) | bypass;
  assign d_pc_o    = d_valid_o ? head.pc    : '0;
  assign d_instr_o = d_valid_o ? head.instr : XLEN'(NOP_INSTR);
  assign count_o   = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        f_valid_i = 1'b0;
  logic [31:0] f_pc_i = '0;
  logic [31:0] f_instr_i = '0;
  logic        f_ready_o;
  logic        d_valid_o;
  logic [31:0] d_pc_o;
  logic [31:0] d_instr_o;
  logic        d_ready_i = 1'b0;
  logic [2:0]  count_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] instr_tab [4];

  fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .f_valid_i (f_valid_i),
    .f_pc_i    (f_pc_i),
    .f_instr_i (f_instr_i),
    .f_ready_o (f_ready_o),
    .d_valid_o (d_valid_o),
    .d_pc_o    (d_pc_o),
    .d_instr_o (d_instr_o),
    .d_ready_i (d_ready_i),
    .count_o   (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    instr_tab[0] = 32'h0050_0093;
    instr_tab[1] = 32'h00A0_0113;
    instr_tab[2] = 32'h0020_81B3;
    instr_tab[3] = 32'h0000_0013;

    // Reset held from time 0
    tick();
    chk("rst_d_valid", d_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_d_instr", d_instr_o, 32'h13);
    chk("rst_d_pc", d_pc_o, 0);
    chk("rst_f_ready", f_ready_o, 0);
    rst_i = 1'b0;
    tick();
    chk("post_rst_f_ready", f_ready_o, 1);

    // Ordering + full hold
    for (int i = 0; i < 4; i++) begin
      f_valid_i = 1'b1;
      f_pc_i    = 32'(4 * i);
      f_instr_i = instr_tab[i];
      tick();
    end
    f_pc_i    = 32'h10;
    f_instr_i = 32'h0100_0113;
    #1;
    chk("full_count", count_o, 4);
    chk("full_f_ready", f_ready_o, 0);
    chk("full_d_valid", d_valid_o, 1);
    tick();
    chk("full_hold_count", count_o, 4);
    d_ready_i = 1'b1;
    #1;
    chk("pop0_pc", d_pc_o, 32'h0);
    chk("pop0_instr", d_instr_o, instr_tab[0]);
    tick();
    chk("after_pop_f_ready", f_ready_o, 1);
    chk("after_pop_count", count_o, 3);
    chk("pop1_pc", d_pc_o, 32'h4);
    chk("pop1_instr", d_instr_o, instr_tab[1]);
    tick();
    f_valid_i = 1'b0;
    #1;
    chk("pushpop_count", count_o, 3);
    chk("pop2_pc", d_pc_o, 32'h8);
    chk("pop2_instr", d_instr_o, instr_tab[2]);
    tick();
    chk("pop3_pc", d_pc_o, 32'hC);
    chk("pop3_instr", d_instr_o, instr_tab[3]);
    chk("pop3_valid", d_valid_o, 1);
    tick();
    chk("tail_pc", d_pc_o, 32'h10);
    chk("tail_instr", d_instr_o, 32'h0100_0113);
    chk("tail_count", count_o, 1);
    tick();
    d_ready_i = 1'b0;
    #1;
    chk("drained_count", count_o, 0);
    chk("drained_valid", d_valid_o, 0);
    chk("drained_instr", d_instr_o, 32'h13);

    // Simultaneous push/pop with pointer wrap
    for (int i = 0; i < 2; i++) begin
      f_valid_i = 1'b1;
      f_pc_i    = 32'h100 + 32'(4 * i);
      f_instr_i = 32'hA000_0000 + 32'h100 + 32'(4 * i);
      tick();
    end
    d_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      f_valid_i = 1'b1;
      f_pc_i    = 32'h108 + 32'(4 * k);
      f_instr_i = 32'hA000_0000 + 32'h108 + 32'(4 * k);
      #1;
      chk("pp_count", count_o, 2);
      chk("pp_pc", d_pc_o, 32'h100 + 32'(4 * k));
      chk("pp_instr", d_instr_o, 32'hA000_0100 + 32'(4 * k));
      tick();
    end
    f_valid_i = 1'b0;
    #1;
    chk("pp_end_count", count_o, 2);
    chk("pp_drain0_pc", d_pc_o, 32'h128);
    tick();
    chk("pp_drain1_pc", d_pc_o, 32'h12C);
    chk("pp_drain1_instr", d_instr_o, 32'hA000_012C);
    tick();
    d_ready_i = 1'b0;
    chk("pp_drained", count_o, 0);

    // Flush with concurrent push
    for (int i = 0; i < 3; i++) begin
      f_valid_i = 1'b1;
      f_pc_i    = 32'h30 + 32'(4 * i);
      f_instr_i = 32'h30 + 32'(4 * i);
      tick();
    end
    chk("pre_flush_count", count_o, 3);
    flush_i   = 1'b1;
    f_pc_i    = 32'h40;
    f_instr_i = 32'h40;
    #1;
    chk("flush_d_valid", d_valid_o, 0);
    chk("flush_d_instr", d_instr_o, 32'h13);
    tick();
    flush_i   = 1'b0;
    f_valid_i = 1'b0;
    #1;
    chk("post_flush_count", count_o, 0);
    chk("post_flush_valid", d_valid_o, 0);
    f_valid_i = 1'b1;
    f_pc_i    = 32'h50;
    f_instr_i = 32'h50;
    tick();
    f_valid_i = 1'b0;
    #1;
    chk("after_flush_count", count_o, 1);
    chk("after_flush_pc", d_pc_o, 32'h50);
    d_ready_i = 1'b1;
    tick();
    d_ready_i = 1'b0;
    chk("after_flush_empty", count_o, 0);

    // Reset mid-run with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      f_valid_i = 1'b1;
      f_pc_i    = 32'h60 + 32'(4 * i);
      f_instr_i = 32'h60 + 32'(4 * i);
      tick();
    end
    f_valid_i = 1'b0;
    chk("pre_rst_count", count_o, 3);
    rst_i = 1'b1;
    #1;
    chk("midrst_d_valid", d_valid_o, 0);
    chk("midrst_count", count_o, 0);
    chk("midrst_d_instr", d_instr_o, 32'h13);
    chk("midrst_f_ready", f_ready_o, 0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("midrst_release_f_ready", f_ready_o, 1);
    chk("midrst_release_count", count_o, 0);

    // Bypass / minimum latency
    f_valid_i = 1'b1;
    f_pc_i    = 32'h80;
    f_instr_i = 32'h0080_0093;
    d_ready_i = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_same_valid", d_valid_o, 1);
    chk("byp_same_pc", d_pc_o, 32'h80);
    tick();
    f_valid_i = 1'b0;
    #1;
    chk("byp_count", count_o, 0);
    chk("byp_after_valid", d_valid_o, 0);
`else
    chk("nobyp_same_valid", d_valid_o, 0);
    tick();
    f_valid_i = 1'b0;
    #1;
    chk("nobyp_next_valid", d_valid_o, 1);
    chk("nobyp_next_pc", d_pc_o, 32'h80);
    chk("nobyp_next_count", count_o, 1);
    tick();
    chk("nobyp_final_count", count_o, 0);
`endif
    d_ready_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
